// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the subleq_ram port arbiter.
// Requester indices and the round-robin pointer type.
package ram_arb_pkg;

  localparam int NREQ      = 3;
  localparam int REQ_CPU   = 0;
  localparam int REQ_HOST  = 1;
  localparam int REQ_TRUSH = 2;

  typedef logic [1:0] rr_ptr_t;

  // Pointer value that gives the just-served requester lowest priority.
  function automatic rr_ptr_t rr_next(input logic [2:0] gnt);
    rr_ptr_t nxt;
    nxt = 2'd0;
    unique case (1'b1)
      gnt[0]:  nxt = 2'd1;
      gnt[1]:  nxt = 2'd2;
      gnt[2]:  nxt = 2'd0;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin picker with a registered priority pointer.
// Grant is combinational and forced to zero while reset is held.
module rr_arb3
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  output logic [2:0] gnt
);

  rr_ptr_t    ptr;
  logic [2:0] pick;

  always_comb begin
    pick = 3'b000;
    case (ptr)
      2'd1: begin
        if (req[1])      pick = 3'b010;
        else if (req[2]) pick = 3'b100;
        else if (req[0]) pick = 3'b001;
      end
      2'd2: begin
        if (req[2])      pick = 3'b100;
        else if (req[0]) pick = 3'b001;
        else if (req[1]) pick = 3'b010;
      end
      default: begin
        if (req[0])      pick = 3'b001;
        else if (req[1]) pick = 3'b010;
        else if (req[2]) pick = 3'b100;
      end
    endcase
  end

  assign gnt = rst_n ? pick : 3'b000;

  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr <= 2'd0;
    else if (|gnt)
      ptr <= rr_next(gnt);
  end

endmodule

// File: rtl/subleq_ram_arb.sv
// Read/write port arbiter in front of subleq_ram for CPU, host and trush.
// Same-cycle read/write to one address forwards the new data to the reader.
module subleq_ram_arb #(
  parameter int AW   = 8,
  parameter int DW   = 8,
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   rreq,
  input  logic [NREQ*AW-1:0] radr,
  output logic [NREQ-1:0]   rgnt,
  output logic [NREQ-1:0]   rvld,
  output logic [DW-1:0]     rdata,
  input  logic [NREQ-1:0]   wreq,
  input  logic [NREQ*AW-1:0] wadr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]   wgnt,
  output logic [AW-1:0]     ram_radr,
  input  logic [DW-1:0]     ram_rdata,
  output logic [AW-1:0]     ram_wadr,
  output logic [DW-1:0]     ram_wdata,
  output logic              ram_wen
);

  import ram_arb_pkg::REQ_CPU;

  logic          fwd_vld;
  logic [DW-1:0] fwd_data;
  logic          collide;

  rr_arb3 u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rreq),
    .gnt   (rgnt)
  );

  rr_arb3 u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wreq),
    .gnt   (wgnt)
  );

  always_comb begin
    ram_radr = radr[REQ_CPU*AW +: AW];
    for (int i = 0; i < NREQ; i++) begin
      if (rgnt[i])
        ram_radr = radr[i*AW +: AW];
    end
  end

  always_comb begin
    ram_wadr  = wadr[REQ_CPU*AW +: AW];
    ram_wdata = wdata[REQ_CPU*DW +: DW];
    for (int i = 0; i < NREQ; i++) begin
      if (wgnt[i]) begin
        ram_wadr  = wadr[i*AW +: AW];
        ram_wdata = wdata[i*DW +: DW];
      end
    end
  end

  assign ram_wen = |wgnt;

  // RAM returns pre-write data on a collision, so capture the write.
  assign collide = (|rgnt) && (|wgnt) && (ram_radr == ram_wadr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvld     <= '0;
      fwd_vld  <= 1'b0;
      fwd_data <= '0;
    end else begin
      rvld     <= rgnt;
      fwd_vld  <= collide;
      fwd_data <= ram_wdata;
    end
  end

  assign rdata = fwd_vld ? fwd_data : ram_rdata;

endmodule

// File: tb/tb_subleq_ram_arb.sv
// Directed bench for subleq_ram_arb with a behavioural synchronous RAM.
// Inputs change 1 unit after the rising edge; outputs sampled 2 units after.
module tb_subleq_ram_arb;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NR = 3;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    rreq;
  logic [NR*AW-1:0] radr;
  logic [NR-1:0]    rgnt;
  logic [NR-1:0]    rvld;
  logic [DW-1:0]    rdata;
  logic [NR-1:0]    wreq;
  logic [NR*AW-1:0] wadr;
  logic [NR*DW-1:0] wdata;
  logic [NR-1:0]    wgnt;
  logic [AW-1:0]    ram_radr;
  logic [DW-1:0]    ram_rdata;
  logic [AW-1:0]    ram_wadr;
  logic [DW-1:0]    ram_wdata;
  logic             ram_wen;

  logic [DW-1:0] mem [256];

  int checks = 0;
  int errors = 0;

  subleq_ram_arb #(.AW(AW), .DW(DW), .NREQ(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rreq      (rreq),
    .radr      (radr),
    .rgnt      (rgnt),
    .rvld      (rvld),
    .rdata     (rdata),
    .wreq      (wreq),
    .wadr      (wadr),
    .wdata     (wdata),
    .wgnt      (wgnt),
    .ram_radr  (ram_radr),
    .ram_rdata (ram_rdata),
    .ram_wadr  (ram_wadr),
    .ram_wdata (ram_wdata),
    .ram_wen   (ram_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_rdata <= mem[ram_radr];
    if (ram_wen)
      mem[ram_wadr] <= ram_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] gseq [6];
  logic [7:0] dseq [6];
  int bad;

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = 8'(i) ^ 8'hA5;
    gseq[0] = 3'b001; gseq[1] = 3'b010; gseq[2] = 3'b100;
    gseq[3] = 3'b001; gseq[4] = 3'b010; gseq[5] = 3'b100;
    dseq[0] = 8'h85;  dseq[1] = 8'h94;  dseq[2] = 8'hE7;
    dseq[3] = 8'h85;  dseq[4] = 8'h94;  dseq[5] = 8'hE7;

    // reset with every request asserted
    rst_n = 1'b0;
    rreq  = 3'b111;
    wreq  = 3'b111;
    radr  = {8'h42, 8'h31, 8'h20};
    wadr  = {8'hF2, 8'hF1, 8'hF0};
    wdata = {8'h33, 8'h22, 8'h11};
    step();
    step();
    #1;
    chk("rst_rgnt", 32'(rgnt), 32'h0);
    chk("rst_wgnt", 32'(wgnt), 32'h0);
    chk("rst_wen", 32'(ram_wen), 32'h0);
    chk("rst_rvld", 32'(rvld), 32'h0);

    // release; first grants go to requester 0
    rst_n = 1'b1;
    #1;
    chk("rel_wgnt", 32'(wgnt), 32'h1);

    // rotating read grants over six cycles
    for (int k = 0; k < 6; k++) begin
      #0;
      chk($sformatf("rr_rgnt%0d", k), 32'(rgnt), 32'(gseq[k]));
      step();
      if (k == 0) wreq = 3'b000;
      if (k == 5) rreq = 3'b000;
      #1;
      chk($sformatf("rr_rvld%0d", k), 32'(rvld), 32'(gseq[k]));
      chk($sformatf("rr_rdata%0d", k), 32'(rdata), 32'(dseq[k]));
    end

    // host writes 0x5A to 0x10 while CPU reads 0x10 (rd_ptr=0, wr_ptr=1)
    rreq = 3'b001;
    radr = {8'h42, 8'h31, 8'h10};
    wreq = 3'b010;
    wadr = {8'hF2, 8'h10, 8'hF0};
    wdata = {8'h33, 8'h5A, 8'h11};
    #1;
    chk("fw_wgnt", 32'(wgnt), 32'h2);
    chk("fw_rgnt", 32'(rgnt), 32'h1);
    chk("fw_wen", 32'(ram_wen), 32'h1);
    chk("fw_radr", 32'(ram_radr), 32'h10);
    chk("fw_wadr", 32'(ram_wadr), 32'h10);
    step();
    rreq = 3'b000;
    wreq = 3'b000;
    #1;
    chk("fw_rvld", 32'(rvld), 32'h1);
    chk("fw_rdata", 32'(rdata), 32'h5A);

    // host re-reads 0x10 from RAM without a collision (rd_ptr=1)
    rreq = 3'b010;
    radr = {8'h42, 8'h10, 8'h20};
    #1;
    chk("hr_rgnt", 32'(rgnt), 32'h2);
    step();
    rreq = 3'b000;
    #1;
    chk("hr_rvld", 32'(rvld), 32'h2);
    chk("hr_rdata", 32'(rdata), 32'h5A);

    // trush clears all 256 addresses on consecutive cycles
    wreq = 3'b100;
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      wadr  = {8'(a), 8'hF1, 8'hF0};
      wdata = {8'h00, 8'h22, 8'h11};
      #1;
      if (wgnt !== 3'b100 || ram_wen !== 1'b1 || ram_wadr !== 8'(a))
        bad++;
      step();
    end
    wreq = 3'b000;
    chk("clr_cycles", 32'(bad), 32'h0);

    // CPU reads every address back (rd_ptr=2, CPU still wins)
    rreq = 3'b001;
    bad = 0;
    for (int a = 0; a < 257; a++) begin
      radr = {8'h42, 8'h31, 8'(a)};
      #1;
      if (a > 0 && (rvld !== 3'b001 || rdata !== 8'h00))
        bad++;
      if (a < 256 && rgnt !== 3'b001)
        bad++;
      if (a == 256) rreq = 3'b000;
      step();
    end
    chk("clr_readback", 32'(bad), 32'h0);

    // CPU read granted then reset asserted before the edge (rd_ptr=1)
    rreq = 3'b001;
    radr = {8'h42, 8'h31, 8'h20};
    #1;
    chk("rd_rgnt", 32'(rgnt), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rd_rgnt_gated", 32'(rgnt), 32'h0);
    rreq = 3'b000;
    step();
    rst_n = 1'b1;
    #1;
    chk("rd_rvld_drop", 32'(rvld), 32'h0);
    step();
    #1;
    chk("rd_rvld_drop2", 32'(rvld), 32'h0);

    // CPU read+write with host read: pointers back at 0 favour CPU
    rreq  = 3'b011;
    radr  = {8'h42, 8'h31, 8'h20};
    wreq  = 3'b001;
    wadr  = {8'hF2, 8'hF1, 8'h50};
    wdata = {8'h33, 8'h22, 8'h77};
    #1;
    chk("dual_rgnt", 32'(rgnt), 32'h1);
    chk("dual_wgnt", 32'(wgnt), 32'h1);
    step();
    rreq = 3'b010;
    wreq = 3'b000;
    #1;
    chk("dual_rgnt2", 32'(rgnt), 32'h2);
    chk("dual_rvld", 32'(rvld), 32'h1);
    chk("dual_rdata", 32'(rdata), 32'h00);
    step();
    rreq = 3'b001;
    radr = {8'h42, 8'h31, 8'h50};
    #1;
    chk("dual_rvld2", 32'(rvld), 32'h2);
    chk("wb_rgnt", 32'(rgnt), 32'h1);
    step();
    rreq = 3'b000;
    #1;
    chk("wb_rvld", 32'(rvld), 32'h1);
    chk("wb_rdata", 32'(rdata), 32'h77);
    chk("idle_radr", 32'(ram_radr), 32'h50);
    chk("idle_rgnt", 32'(rgnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/subleq_ram_arb.md
Name: subleq_ram_arb

Overview:
- Arbitrates the single read port and single write port of subleq_ram among three requesters:
  - 0 = CPU exec (subleq_regs_exec)
  - 1 = host loader/dump (UART command path)
  - 2 = trush memory-clear sequencer
- Independent round-robin arbitration per port, with a req/gnt handshake.
- Read data returns one cycle after grant, with a valid strobe routed to the owning requester.
- Sits between the requesters and subleq_ram, so those blocks no longer drive ram_* directly.

Parameters:
- AW, 8, RAM address width
- DW, 8, RAM data width
- NREQ, 3, number of requesters (fixed at 3; packed vectors sized by it)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- rreq  in  NREQ  per-requester read request; held with radr until granted
- radr  in  NREQ*AW  packed read addresses; requester i uses bits [i*AW +: AW]
- rgnt  out  NREQ  one-hot read grant (combinational)
- rvld  out  NREQ  one-hot read-data valid, one cycle after rgnt
- rdata  out  DW  read data, shared by all requesters; qualified by rvld
- wreq  in  NREQ  per-requester write request; held with wadr/wdata until granted
- wadr  in  NREQ*AW  packed write addresses
- wdata  in  NREQ*DW  packed write data
- wgnt  out  NREQ  one-hot write grant (combinational)
- ram_radr  out  AW  to subleq_ram read address
- ram_rdata  in  DW  from subleq_ram; synchronous read, valid the cycle after ram_radr
- ram_wadr  out  AW  to subleq_ram write address
- ram_wdata  out  DW  to subleq_ram write data
- ram_wen  out  1  to subleq_ram write enable

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - rd_ptr=0, wr_ptr=0, rvld=0, fwd_vld=0.
  - While rst_n is low, rgnt=0, wgnt=0 and ram_wen=0 (gated combinationally).
  - An in-flight read is dropped; no rvld follows reset.
- Read arbitration:
  - Winner = first set rreq bit searched circularly from rd_ptr.
  - rgnt = one-hot winner; ram_radr = radr of the winner.
  - With no request, ram_radr = radr[0 +: AW] and rgnt = 0.
  - On a grant, rd_ptr <= (winner+1) mod 3; otherwise rd_ptr holds.
- Write arbitration:
  - Identical scheme, using wr_ptr.
  - ram_wen = |wgnt; ram_wadr and ram_wdata come from the winner.
  - With no request, ram_wadr and ram_wdata come from requester 0 and ram_wen = 0.
- Handshake:
  - A requester holds req, address and data stable until it sees gnt.
  - It may drop or change them in the cycle after gnt.
  - A requester may re-request in the cycle right after its grant; it then competes again, at lowest priority.
- Read response:
  - rvld <= rgnt, registered one cycle.
  - rdata = ram_rdata in that cycle, except when forwarding applies (next bullet).
  - Latency from grant to data: exactly 1 cycle.
  - Back-to-back grants to different requesters give back-to-back rvld.
- Same-cycle read/write to the same address:
  - Condition: rgnt!=0, wgnt!=0 and ram_radr==ram_wadr.
  - Register fwd_vld=1 and fwd_data=ram_wdata.
  - In the following cycle, rdata = fwd_data, so the read sees the newly written value.
- Read and write ports are independent; one read and one write may be granted in the same cycle, to the same or different requesters.
- A requester asserting rreq and wreq together can receive both grants in one cycle.
- Starvation bound: a continuously requesting requester is granted within 3 cycles on each port.
- Address/data widths are pass-through; there is no arithmetic and no wrap logic beyond the 2-bit pointer mod 3.

Decomposition:
- Shared package ram_arb_pkg:
  - constants REQ_CPU=0, REQ_HOST=1, REQ_TRUSH=2, NREQ=3
  - a typedef for the 2-bit round-robin pointer
- One sub-module, rr_arb3:
  - combinational round-robin picker plus registered pointer
  - inputs: clk, rst_n, req[2:0]
  - outputs: gnt[2:0]
  - instantiated twice, once for the read port and once for the write port.

Test Plan:
- Reset with all req=1 -> rgnt=wgnt=0, ram_wen=0, rvld=0. First cycle after release -> rgnt=3'b001, wgnt=3'b001.
- rreq=3'b111 held for 6 cycles -> rgnt sequence 001,010,100,001,010,100; rvld is the same sequence delayed 1 cycle; each rdata matches RAM contents at the granted address.
- Host writes 0x5A to 0x10 while CPU reads 0x10 in the same cycle -> wgnt=010, rgnt=001; next cycle rvld=001 with rdata=0x5A (forwarded).
- Only TRUSH writes 0x00..0xFF on consecutive cycles -> wgnt=100 every cycle, ram_wen=1 for 256 cycles, all RAM addresses read back as 0.
- CPU read granted, then rst_n=0 for 1 cycle -> no rvld after reset; pointers return to 0.
- CPU issues rreq and wreq together with host rreq -> CPU gets rgnt and wgnt in the same cycle; host rgnt next cycle.
